// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz timing constants, pixel types and RGB565 colours.
package vga_pkg;

  typedef logic [9:0]  coord_t;
  typedef logic [15:0] rgb565_t;

  // Horizontal timing, in pixel clocks
  localparam int unsigned HSync640  = 96;
  localparam int unsigned HBack640  = 48;
  localparam int unsigned HValid640 = 640;
  localparam int unsigned HFront640 = 16;
  localparam int unsigned HTotal640 = HSync640 + HBack640 + HValid640 + HFront640;
  localparam int unsigned HActStart640 = HSync640 + HBack640;

  // Vertical timing, in lines
  localparam int unsigned VSync640  = 2;
  localparam int unsigned VBack640  = 33;
  localparam int unsigned VValid640 = 480;
  localparam int unsigned VFront640 = 10;
  localparam int unsigned VTotal640 = VSync640 + VBack640 + VValid640 + VFront640;
  localparam int unsigned VActStart640 = VSync640 + VBack640;

  // Coordinate value meaning "no pixel requested"
  localparam coord_t CoordIdle = 10'h3FF;

  // RGB565 colours used by the picture generators
  localparam rgb565_t ColBlack   = 16'h0000;
  localparam rgb565_t ColWhite   = 16'hFFFF;
  localparam rgb565_t ColGreen   = 16'h07E0;
  localparam rgb565_t ColYellow  = 16'hFFE0;
  localparam rgb565_t ColMagenta = 16'hF81F;
  localparam rgb565_t ColRed     = 16'hF800;

  // True when lo <= v < hi
  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_ctrl.sv
// VGA timing generator and pixel sink: free-running h/v counters, combinational
// pixel request coordinates and a one-stage registered sync/RGB output.
module vga_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = HSync640,
  parameter int unsigned H_BACK   = HBack640,
  parameter int unsigned H_VALID  = HValid640,
  parameter int unsigned H_FRONT  = HFront640,
  parameter int unsigned V_SYNC   = VSync640,
  parameter int unsigned V_BACK   = VBack640,
  parameter int unsigned V_VALID  = VValid640,
  parameter int unsigned V_FRONT  = VFront640,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        hsync,
  output logic        vsync,
  output logic [15:0] rgb,
  output logic        rgb_valid,
  output logic        frame_start
);

  localparam int unsigned HTotal = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned VTotal = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam coord_t HLast    = coord_t'(HTotal - 1);
  localparam coord_t VLast    = coord_t'(VTotal - 1);
  localparam coord_t HSyncEnd = coord_t'(H_SYNC);
  localparam coord_t VSyncEnd = coord_t'(V_SYNC);
  localparam coord_t HActS    = coord_t'(H_SYNC + H_BACK);
  localparam coord_t HActE    = coord_t'(H_SYNC + H_BACK + H_VALID);
  localparam coord_t VActS    = coord_t'(V_SYNC + V_BACK);
  localparam coord_t VActE    = coord_t'(V_SYNC + V_BACK + V_VALID);

  coord_t  cnt_h_q, cnt_h_d;
  coord_t  cnt_v_q, cnt_v_d;
  logic    h_last, v_last;
  logic    h_act, v_act, req;

  logic    hsync_q, hsync_d;
  logic    vsync_q, vsync_d;
  rgb565_t rgb_q, rgb_d;
  logic    rgb_valid_q, rgb_valid_d;
  logic    frame_start_q, frame_start_d;

  // Counter next state: h wraps every line, v advances only on the h wrap
  always_comb begin
    h_last  = (cnt_h_q == HLast);
    v_last  = (cnt_v_q == VLast);
    cnt_h_d = h_last ? '0 : cnt_h_q + 10'd1;
    cnt_v_d = cnt_v_q;
    if (h_last) begin
      cnt_v_d = v_last ? '0 : cnt_v_q + 10'd1;
    end
  end

  // Counter registers; reset restarts timing from (0,0)
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // Stage 0: visible-region decode and pixel request coordinates
  always_comb begin
    h_act = in_window(cnt_h_q, HActS, HActE);
    v_act = in_window(cnt_v_q, VActS, VActE);
    req   = h_act & v_act;
    pix_x = req ? (cnt_h_q - HActS) : CoordIdle;
    pix_y = req ? (cnt_v_q - VActS) : CoordIdle;
  end

  // Stage 1 next state, all taken from the same counter state so outputs stay aligned
  always_comb begin
    hsync_d       = (cnt_h_q < HSyncEnd) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (cnt_v_q < VSyncEnd) ? SYNC_POL : ~SYNC_POL;
    rgb_valid_d   = req;
    rgb_d         = req ? pix_data : ColBlack;
    frame_start_d = (cnt_h_q == '0) && (cnt_v_q == '0);
  end

  // Stage 1 output registers
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      rgb_q         <= ColBlack;
      rgb_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      rgb_valid_q   <= rgb_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb         = rgb_q;
  assign rgb_valid   = rgb_valid_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl: full 640x480 instance for reset, line and pixel
// timing, plus a small-geometry instance for whole-frame and mid-frame reset checks.
module tb_vga_ctrl;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  // Full-size instance
  logic        rst_n;
  logic        pat_ffff;
  logic [15:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        hsync, vsync, rgb_valid, frame_start;
  logic [15:0] rgb;

  assign pix_data = pat_ffff ? 16'hFFFF : {pix_y[5:0], pix_x};

  vga_ctrl dut (
    .vga_clk     (clk),
    .sys_rst_n   (rst_n),
    .pix_data    (pix_data),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .rgb_valid   (rgb_valid),
    .frame_start (frame_start)
  );

  // Small instance: H = 8/4/16/4 (32), V = 2/3/6/2 (13), frame = 416 clocks
  logic        rst_s_n;
  logic [15:0] pix_data_s;
  logic [9:0]  pix_x_s, pix_y_s;
  logic        hsync_s, vsync_s, rgb_valid_s, frame_start_s;
  logic [15:0] rgb_s;

  assign pix_data_s = {pix_y_s[5:0], pix_x_s};

  vga_ctrl #(
    .H_SYNC  (8),
    .H_BACK  (4),
    .H_VALID (16),
    .H_FRONT (4),
    .V_SYNC  (2),
    .V_BACK  (3),
    .V_VALID (6),
    .V_FRONT (2)
  ) dut_s (
    .vga_clk     (clk),
    .sys_rst_n   (rst_s_n),
    .pix_data    (pix_data_s),
    .pix_x       (pix_x_s),
    .pix_y       (pix_y_s),
    .hsync       (hsync_s),
    .vsync       (vsync_s),
    .rgb         (rgb_s),
    .rgb_valid   (rgb_valid_s),
    .frame_start (frame_start_s)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;
  int s_edge = 0;
  int last_fall = 0;
  logic prev_hs = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 ns after the edge and track hsync falling edges of the full DUT
  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
    s_edge++;
    if (prev_hs === 1'b1 && hsync === 1'b0) last_fall = edge_n;
    prev_hs = hsync;
  endtask

  initial begin
    #(40 * 100000);
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hlow, vbad, fs_cnt, run, guard, nvalid, blank_bad, px_bad;
    int vlow, nfs, fs1, fs2, coinc_bad, nval_s, have_first;
    logic [15:0] last_rgb, first_rgb_s, last_rgb_s;
    logic        prev_vs, fell;
    int h, v;
    logic [9:0] ex, ey;

    rst_n    = 1'b0;
    rst_s_n  = 1'b0;
    pat_ffff = 1'b0;
    repeat (5) step();

    // Reset state
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_rgb", 32'(rgb), 32'h0);
    check("rst_rgb_valid", 32'(rgb_valid), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_pix_x", 32'(pix_x), 32'h3FF);
    check("rst_pix_y", 32'(pix_y), 32'h3FF);

    // First edge after release reflects counter (0,0)
    rst_n   = 1'b1;
    rst_s_n = 1'b1;
    edge_n  = 0;
    s_edge  = 0;
    prev_hs = 1'b1;
    step();
    check("first_hsync", 32'(hsync), 32'd0);
    check("first_vsync", 32'(vsync), 32'd0);
    check("first_frame_start", 32'(frame_start), 32'd1);
    check("first_rgb_valid", 32'(rgb_valid), 32'd0);
    check("first_fs_small", 32'(frame_start_s), 32'd1);

    // Line timing over 3 lines (edges 1..2400)
    hlow   = (hsync === 1'b0) ? 1 : 0;
    vbad   = 0;
    fs_cnt = 1;
    while (edge_n < 2400) begin
      step();
      if (hsync === 1'b0) hlow++;
      if (rgb_valid !== 1'b0) vbad++;
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("hsync_low_3_lines", 32'(hlow), 32'd288);
    check("fs_count_3_lines", 32'(fs_cnt), 32'd1);
    check("last_hsync_fall_line2", 32'(last_fall), 32'd1601);

    // Run to the first visible pixel; rgb_valid must stay low until edge 28145
    while (edge_n < 28143) begin
      step();
      if (rgb_valid !== 1'b0) vbad++;
    end
    check("no_early_rgb_valid", 32'(vbad), 32'd0);
    check("pix_x_before_vis", 32'(pix_x), 32'h3FF);
    step();
    check("pix_x_first_vis", 32'(pix_x), 32'd0);
    check("pix_y_first_vis", 32'(pix_y), 32'd0);
    check("rgb_valid_at_28144", 32'(rgb_valid), 32'd0);
    step();
    check("rgb_valid_at_28145", 32'(rgb_valid), 32'd1);
    check("rgb_first_pixel", 32'(rgb), 32'h0000);
    check("hsync_fall_to_valid", 32'(edge_n - last_fall), 32'd144);

    // Active run length and last pixel of line 0
    run = 0;
    guard = 0;
    last_rgb = '0;
    while (rgb_valid === 1'b1 && guard < 1000) begin
      run++;
      last_rgb = rgb;
      step();
      guard++;
    end
    check("rgb_valid_run", 32'(run), 32'd640);
    check("rgb_last_of_line0", 32'(last_rgb), 32'h027F);
    check("rgb_blank_after_run", 32'(rgb), 32'h0);

    // Blanking and pix_x/pix_y mapping over one full line with pix_data = FFFF
    pat_ffff  = 1'b1;
    nvalid    = 0;
    blank_bad = 0;
    px_bad    = 0;
    repeat (800) begin
      step();
      if (rgb_valid === 1'b1) nvalid++;
      if (rgb !== (rgb_valid ? 16'hFFFF : 16'h0000)) blank_bad++;
      h  = edge_n % 800;
      v  = (edge_n / 800) % 525;
      ex = (h >= 144 && h < 784 && v >= 35 && v < 515) ? 10'(h - 144) : 10'h3FF;
      ey = (h >= 144 && h < 784 && v >= 35 && v < 515) ? 10'(v - 35) : 10'h3FF;
      if (pix_x !== ex || pix_y !== ey) px_bad++;
    end
    check("blank_line_valid_count", 32'(nvalid), 32'd640);
    check("blank_rgb_mismatches", 32'(blank_bad), 32'd0);
    check("pix_xy_mismatches", 32'(px_bad), 32'd0);

    // Small instance: fresh reset, then two whole frames
    rst_s_n = 1'b0;
    step();
    rst_s_n = 1'b1;
    s_edge  = 0;
    prev_vs = 1'b1;
    vlow = 0; nfs = 0; fs1 = 0; fs2 = 0; coinc_bad = 0; nval_s = 0; have_first = 0;
    first_rgb_s = '1;
    last_rgb_s  = '1;
    repeat (832) begin
      step();
      if (vsync_s === 1'b0) vlow++;
      fell = (prev_vs === 1'b1) && (vsync_s === 1'b0);
      if (frame_start_s !== fell) coinc_bad++;
      if (frame_start_s === 1'b1) begin
        nfs++;
        if (nfs == 1) fs1 = s_edge;
        else if (nfs == 2) fs2 = s_edge;
      end
      if (s_edge <= 416 && rgb_valid_s === 1'b1) begin
        if (have_first == 0) begin
          first_rgb_s = rgb_s;
          have_first  = 1;
        end
        last_rgb_s = rgb_s;
        nval_s++;
      end
      prev_vs = vsync_s;
    end
    check("s_vsync_low_2_frames", 32'(vlow), 32'd128);
    check("s_frame_start_count", 32'(nfs), 32'd2);
    check("s_frame_start_first", 32'(fs1), 32'd1);
    check("s_frame_period", 32'(fs2 - fs1), 32'd416);
    check("s_fs_vsync_coincide", 32'(coinc_bad), 32'd0);
    check("s_valid_per_frame", 32'(nval_s), 32'd96);
    check("s_first_pixel", 32'(first_rgb_s), 32'h0000);
    check("s_last_pixel", 32'(last_rgb_s), 32'h140F);

    // Mid-frame reset at (v=7, h=20), i.e. counter state 244
    guard = 0;
    while ((s_edge % 416) != 244 && guard < 500) begin
      step();
      guard++;
    end
    check("s_reach_state_244", 32'(s_edge % 416), 32'd244);
    check("s_pix_x_at_244", 32'(pix_x_s), 32'd8);
    check("s_pix_y_at_244", 32'(pix_y_s), 32'd2);
    rst_s_n = 1'b0;
    step();
    check("s_mid_rst_hsync", 32'(hsync_s), 32'd1);
    check("s_mid_rst_vsync", 32'(vsync_s), 32'd1);
    check("s_mid_rst_rgb", 32'(rgb_s), 32'h0);
    check("s_mid_rst_valid", 32'(rgb_valid_s), 32'd0);
    check("s_mid_rst_fs", 32'(frame_start_s), 32'd0);
    check("s_mid_rst_pix_x", 32'(pix_x_s), 32'h3FF);
    rst_s_n = 1'b1;
    s_edge  = 0;
    guard   = 0;
    step();
    check("s_mid_rel_fs", 32'(frame_start_s), 32'd1);
    while (rgb_valid_s !== 1'b1 && guard < 400) begin
      step();
      guard++;
    end
    check("s_first_valid_edge", 32'(s_edge), 32'd173);
    check("s_first_valid_rgb", 32'(rgb_s), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

Timing generator and pixel sink for the 640x480@60 Hz display path, clocked from the 25 MHz pixel clock. It produces the horizontal and vertical sync pulses and asks the picture generator for each visible pixel by driving `pix_x`/`pix_y`. It takes back the returned `pix_data` and drives the registered RGB565 stream to the DAC/connector. It sits between the picture generators (game screens, menus) and the board video pins.

## Interface
Parameters:
- `H_SYNC`, 96: hsync pulse width, in clocks
- `H_BACK`, 48: horizontal back porch
- `H_VALID`, 640: visible pixels per line
- `H_FRONT`, 16: horizontal front porch (H_TOTAL = 800)
- `V_SYNC`, 2: vsync pulse width, in lines
- `V_BACK`, 33: vertical back porch
- `V_VALID`, 480: visible lines
- `V_FRONT`, 10: vertical front porch (V_TOTAL = 525)
- `SYNC_POL`, 0: level of the sync pulses while asserted (0 = active-low)

Ports:
- `vga_clk` in 1: 25 MHz pixel clock, the only clock
- `sys_rst_n` in 1: synchronous, active-low reset
- `pix_data` in 16: RGB565 from the picture generator, combinational response to `pix_x`/`pix_y`
- `pix_x` out 10: visible column 0..639, or 10'h3FF when not requesting
- `pix_y` out 10: visible row 0..479, or 10'h3FF when not requesting
- `hsync` out 1: registered horizontal sync
- `vsync` out 1: registered vertical sync
- `rgb` out 16: registered pixel; 0 during blanking
- `rgb_valid` out 1: registered data-enable
- `frame_start` out 1: registered one-cycle pulse at the start of each frame

## Operation
Counters:
- `cnt_h` runs 0..H_TOTAL-1 and wraps to 0.
- `cnt_v` increments only on the `cnt_h` wrap, runs 0..V_TOTAL-1 and wraps to 0 on the last clock of the frame.
- Both counters are 10 bits and are unsigned throughout.

Regions, stage 0 (combinational from the counters):
- `h_act` = `cnt_h` in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID), i.e. [144, 784).
- `v_act` = `cnt_v` in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID), i.e. [35, 515).
- `req` = `h_act` & `v_act`.
- While `req`: `pix_x` = `cnt_h` − 144 and `pix_y` = `cnt_v` − 35. Otherwise both are 10'h3FF.
- `pix_x`/`pix_y` are the only combinational outputs.

Outputs, stage 1 (registered on the rising edge of `vga_clk`):
- `hsync` = SYNC_POL when `cnt_h` < H_SYNC, else ~SYNC_POL.
- `vsync` = SYNC_POL when `cnt_v` < V_SYNC, else ~SYNC_POL.
- `rgb_valid` = `req`.
- `rgb` = `req` ? `pix_data` : 16'h0000.
- `frame_start` = (`cnt_h` == 0 && `cnt_v` == 0).

Reset:
- While `sys_rst_n` = 0 at a clock edge: counters are 0, `hsync` = `vsync` = ~SYNC_POL (1), `rgb` = 0, `rgb_valid` = 0, `frame_start` = 0.
- `pix_x`/`pix_y` read 10'h3FF, because the counters sit at (0,0), which is outside the visible region.
- A mid-frame reset takes effect at the next edge. Timing restarts from (0,0); no partial line is completed.

## Timing
- Latency is 1 clock from counter state to every registered output. Sync, data-enable and `rgb` are therefore mutually aligned.
- `pix_data` must be valid within the same cycle `pix_x`/`pix_y` are driven. There is no handshake and no back-pressure.
- First edge after reset is released: outputs reflect counter (0,0), so `hsync` and `vsync` go active and `frame_start` = 1.
- Counter state N (N = `cnt_v`·800 + `cnt_h`) appears on the outputs after edge N+1 following release.
- Line period is 800 clocks. Frame period is 420,000 clocks.
- `frame_start` fires once per frame, on the same cycle as the vsync leading edge.

## Structure
- Shared package `vga_pkg`: the 640x480 timing constants, the H_TOTAL/V_TOTAL and active-start constants, and the RGB565 colour constants (black, white, green, yellow, magenta, red) used by the picture generators.
- Flat module, no sub-module.

## Test plan
- Reset: hold `sys_rst_n` = 0 for 5 clocks. Expect `hsync` = `vsync` = 1, `rgb` = 0, `rgb_valid` = 0, `frame_start` = 0, `pix_x` = `pix_y` = 10'h3FF. On the first edge after release, expect `hsync` = 0, `vsync` = 0, `frame_start` = 1.
- Line timing: measure over 3 lines. Expect `hsync` low for 96 of every 800 clocks. During visible lines, `rgb_valid` rises 144 clocks after the hsync falling edge and stays high for exactly 640 clocks.
- Frame timing: expect `vsync` low for exactly 1600 clocks, a frame period of 420,000 clocks, and one `frame_start` per frame, coincident with the vsync falling edge.
- Pixel mapping: drive `pix_data` = {`pix_y`[5:0], `pix_x`}. Expect the last `rgb_valid` cycle of a frame to show `rgb` = 16'h7E7F (x = 639, y = 479), and the first to show 16'h0000 (x = 0, y = 0).
- Blanking: hold `pix_data` = 16'hFFFF. Expect `rgb` = 16'h0000 whenever `rgb_valid` = 0 and 16'hFFFF whenever it is 1. Expect `pix_x` = 10'h3FF whenever `cnt_h` ∉ [144, 784).
- Mid-frame reset: pulse `sys_rst_n` low for 1 clock at `cnt_v` = 200, `cnt_h` = 300. Expect reset values on the next edge. Expect the first `rgb_valid` after release on edge 28,145.
